// File: rtl/captura_jogada_if.sv
// Control-side bundle of the play capture block: enable and raw buttons in,
// registered play, status pulses and debug state out.
interface captura_jogada_if #(
  parameter int N = 4
);
  logic         habilita;
  logic [N-1:0] botoes;
  logic [N-1:0] jogada;
  logic         jogada_valida;
  logic         timeout;
  logic         erro_multiplo;
  logic [2:0]   db_estado;

  modport master (
    output habilita, botoes,
    input  jogada, jogada_valida, timeout, erro_multiplo, db_estado
  );

  modport slave (
    input  habilita, botoes,
    output jogada, jogada_valida, timeout, erro_multiplo, db_estado
  );
endinterface

// File: rtl/captura_jogada.sv
// Player-input capture: debounces the button vector, enforces a single button
// per play, and reports accepted play, play timeout and multi-button errors.
module captura_jogada #(
  parameter int N        = 4,
  parameter int DEBOUNCE = 3,
  parameter int TIMEOUT  = 5000
) (
  input  logic             clock,
  input  logic             reset,
  captura_jogada_if.slave  bus
);
  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    INATIVO       = 3'd0,
    ESPERA        = 3'd1,
    ESTABILIZA    = 3'd2,
    REGISTRA      = 3'd3,
    ESPERA_SOLTAR = 3'd4
  } estado_t;

  estado_t       estado, estado_n;
  logic [N-1:0]  cand, cand_n;
  logic [N-1:0]  jog, jog_n;
  logic [DW-1:0] cnt, cnt_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic          val_q, val_n;
  logic          tmo_q, tmo_n;
  logic          err_q, err_n;

  logic solto, deb_done, tmo_hit;
  assign solto    = (bus.botoes == '0);
  assign deb_done = (cnt == DW'(DEBOUNCE));
  // Registered count lags by one, so hitting TIMEOUT-1 here means this edge is the TIMEOUT-th
  assign tmo_hit  = (tcnt == TW'(TIMEOUT - 1));

  always_comb begin
    estado_n = estado;
    cand_n   = cand;
    cnt_n    = cnt;
    tcnt_n   = tcnt;
    jog_n    = jog;
    val_n    = 1'b0;
    tmo_n    = 1'b0;
    err_n    = 1'b0;
    if (!bus.habilita) begin
      estado_n = INATIVO;
    end else begin
      case (estado)
        INATIVO: estado_n = solto ? ESPERA : ESPERA_SOLTAR;
        ESPERA: begin
          cnt_n  = '0;
          tcnt_n = tcnt + TW'(1);
          if (tmo_hit) begin
            tmo_n    = 1'b1;
            estado_n = INATIVO;
          end else if (!solto) begin
            estado_n = ESTABILIZA;
            cand_n   = bus.botoes;
            cnt_n    = DW'(1);
          end
        end
        ESTABILIZA: begin
          tcnt_n = tcnt + TW'(1);
          // A completed debounce outranks a coincident timeout
          if (deb_done) begin
            if ($onehot(cand)) begin
              estado_n = REGISTRA;
              jog_n    = cand;
              val_n    = 1'b1;
            end else begin
              estado_n = ESPERA_SOLTAR;
              err_n    = 1'b1;
            end
          end else if (tmo_hit) begin
            tmo_n    = 1'b1;
            estado_n = INATIVO;
          end else if (solto) begin
            estado_n = ESPERA;
          end else if (bus.botoes == cand) begin
            cnt_n = cnt + DW'(1);
          end else begin
            cand_n = bus.botoes;
            cnt_n  = DW'(1);
          end
        end
        REGISTRA:      estado_n = ESPERA_SOLTAR;
        ESPERA_SOLTAR: if (solto) estado_n = ESPERA;
        default:       estado_n = INATIVO;
      endcase
    end
    if (estado_n == ESPERA && estado != ESPERA) begin
      tcnt_n = '0;
      cnt_n  = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado <= INATIVO;
      cand   <= '0;
      jog    <= '0;
      cnt    <= '0;
      tcnt   <= '0;
      val_q  <= 1'b0;
      tmo_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      estado <= estado_n;
      cand   <= cand_n;
      jog    <= jog_n;
      cnt    <= cnt_n;
      tcnt   <= tcnt_n;
      val_q  <= val_n;
      tmo_q  <= tmo_n;
      err_q  <= err_n;
    end
  end

  assign bus.jogada        = jog;
  assign bus.jogada_valida = val_q;
  assign bus.timeout       = tmo_q;
  assign bus.erro_multiplo = err_q;
  assign bus.db_estado     = estado;
endmodule

// File: tb/tb_captura_jogada.sv
// Scoreboard bench: stimulus queues expected pulses with their edge number;
// a negedge monitor pops and compares every pulse the block emits.
module tb_captura_jogada;
  localparam int N = 4, DEB = 3, TMO = 20;
  localparam logic [2:0] K_VAL = 3'b100, K_TMO = 3'b010, K_ERR = 3'b001;

  logic clk, reset;
  int   edge_n = 0;
  int   total = 0, bad = 0;

  typedef struct {
    logic [2:0]   kind;
    logic [N-1:0] val;
    int           at;
  } exp_t;
  exp_t q[$];

  captura_jogada_if #(.N(N)) bus();

  captura_jogada #(.N(N), .DEBOUNCE(DEB), .TIMEOUT(TMO)) dut (
    .clock (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) edge_n++;

  initial begin
    #200000;
    $display("FAIL watchdog: act=running req=finished");
    $fatal(1, "watchdog");
  end

  // Monitor: every pulse must match the head of the expectation queue
  always @(negedge clk) begin
    logic [2:0] got;
    exp_t e;
    got = {bus.jogada_valida, bus.timeout, bus.erro_multiplo};
    if (got != 3'b000) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_pulse: act kind=%b jogada=%b edge=%0d req=none",
                 got, bus.jogada, edge_n);
      end else begin
        e = q.pop_front();
        if (got != e.kind || bus.jogada != e.val || edge_n != e.at) begin
          bad++;
          $display("FAIL pulse: act kind=%b jogada=%b edge=%0d req kind=%b jogada=%b edge=%0d",
                   got, bus.jogada, edge_n, e.kind, e.val, e.at);
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: act=%0d req=%0d", nm, act, req);
    end
  endtask

  task automatic expect_ev(input logic [2:0] k, input logic [N-1:0] v, input int at);
    exp_t e;
    e.kind = k; e.val = v; e.at = at;
    q.push_back(e);
  endtask

  // Hold v from ESPERA until the block resolves it, then release
  task automatic press(input logic [N-1:0] v, input logic [2:0] k, input logic [N-1:0] jv);
    bus.botoes = v;
    expect_ev(k, jv, edge_n + 1 + DEB);
    tick(DEB + 1);
    chk("resolve_state", int'(bus.db_estado), (k == K_VAL) ? 3 : 4);
    chk("resolve_jogada", int'(bus.jogada), int'(jv));
    tick(2);
    chk("held_state", int'(bus.db_estado), 4);
    bus.botoes = '0;
    tick();
    chk("release_state", int'(bus.db_estado), 1);
  endtask

  initial begin
    int r;
    reset = 1'b1; bus.habilita = 1'b0; bus.botoes = '0;
    tick();
    chk("rst_jogada", int'(bus.jogada), 0);
    chk("rst_pulses", int'({bus.jogada_valida, bus.timeout, bus.erro_multiplo}), 0);
    chk("rst_state", int'(bus.db_estado), 0);
    reset = 1'b0; bus.habilita = 1'b1;
    tick();
    chk("enter_espera", int'(bus.db_estado), 1);

    // clean single press
    press(4'b0100, K_VAL, 4'b0100);

    // bounce returns to ESPERA, then a clean run
    bus.botoes = 4'b0010; tick();
    chk("bounce_estab", int'(bus.db_estado), 2);
    bus.botoes = 4'b0000; tick();
    chk("bounce_back", int'(bus.db_estado), 1);
    press(4'b0010, K_VAL, 4'b0010);

    // two buttons: error, play unchanged
    press(4'b0011, K_ERR, 4'b0010);

    // idle timeout, then a press seen in INATIVO must be released first
    r = edge_n;
    expect_ev(K_TMO, 4'b0010, r + TMO);
    tick(TMO);
    chk("tmo_state", int'(bus.db_estado), 0);
    bus.botoes = 4'b0001; tick();
    chk("held_after_tmo", int'(bus.db_estado), 4);
    tick(3);
    chk("still_held", int'(bus.db_estado), 4);
    bus.botoes = '0; tick();
    chk("tmo_release", int'(bus.db_estado), 1);

    // acceptance on the timeout edge wins
    tick(TMO - DEB - 1);
    press(4'b0001, K_VAL, 4'b0001);
    // error on the timeout edge wins
    tick(TMO - DEB - 1);
    press(4'b0110, K_ERR, 4'b0001);

    // button already down when enable rises
    bus.habilita = 1'b0; tick();
    chk("disable_state", int'(bus.db_estado), 0);
    bus.botoes = 4'b1000; bus.habilita = 1'b1; tick();
    chk("enable_held", int'(bus.db_estado), 4);
    tick(3);
    chk("enable_held2", int'(bus.db_estado), 4);
    bus.botoes = '0; tick();
    chk("enable_rel", int'(bus.db_estado), 1);
    press(4'b1000, K_VAL, 4'b1000);

    // enable drop mid-debounce: no pulse, play retained
    bus.botoes = 4'b0100; tick(2);
    bus.habilita = 1'b0; tick();
    chk("drop_state", int'(bus.db_estado), 0);
    chk("drop_jogada", int'(bus.jogada), 4'b1000);
    bus.botoes = '0; bus.habilita = 1'b1; tick();
    chk("drop_reenter", int'(bus.db_estado), 1);

    // reset mid-debounce discards everything
    bus.botoes = 4'b0001; tick(2);
    chk("pre_rst_state", int'(bus.db_estado), 2);
    reset = 1'b1; tick();
    chk("mid_rst_jogada", int'(bus.jogada), 0);
    chk("mid_rst_state", int'(bus.db_estado), 0);
    chk("mid_rst_pulses", int'({bus.jogada_valida, bus.timeout, bus.erro_multiplo}), 0);
    reset = 1'b0; tick();
    chk("post_rst_held", int'(bus.db_estado), 4);
    tick(3);
    chk("post_rst_held2", int'(bus.db_estado), 4);
    bus.botoes = '0; tick();
    chk("post_rst_rel", int'(bus.db_estado), 1);
    press(4'b0001, K_VAL, 4'b0001);

    tick(3);
    chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/captura_jogada.md
Name: captura_jogada

Overview:
- Player-input capture front end for the memory-game datapath.
- Samples the raw button vector, debounces it, and enforces one button per play.
- Delivers a registered play value plus a one-cycle valid strobe; this is the value the equality comparator checks against the stored sequence element.
- Also signals a play timeout and an illegal multi-button press to the control unit.

Parameters:
N, 4, button/play width in bits (one-hot play encoding)
DEBOUNCE, 3, consecutive identical nonzero samples required to accept a press (>=1)
TIMEOUT, 5000, clock cycles allowed in the wait phase before timeout (>=DEBOUNCE+1)

Ports:
clock  input  1  system clock; all state updates on its rising edge
reset  input  1  synchronous, active-high reset
habilita  input  1  capture enable from control unit; low forces INATIVO
botoes  input  N  raw button levels, already synchronised to clock
jogada  output  N  last accepted play, held until the next accepted play or reset
jogada_valida  output  1  one-cycle pulse on the edge jogada updates
timeout  output  1  one-cycle pulse when no play is accepted within TIMEOUT
erro_multiplo  output  1  one-cycle pulse when a debounced press has more than one bit set
db_estado  output  3  current FSM state code, for debug display

Behaviour:
Reset (synchronous, active-high, wins over everything):
- State goes to INATIVO; jogada=0; jogada_valida=timeout=erro_multiplo=0; counters=0.

All outputs are registered. Pulses last exactly one cycle and at most one pulse is asserted per cycle.

FSM state codes:
- INATIVO=0, ESPERA=1, ESTABILIZA=2, REGISTRA=3, ESPERA_SOLTAR=4.

Transitions:
- INATIVO: if habilita=1 and botoes=0 -> ESPERA. If habilita=1 and botoes!=0 -> ESPERA_SOLTAR (a button held at enable is never accepted).
- ESPERA: clear the debounce counter. botoes!=0 -> ESTABILIZA; latch the sample as candidate; debounce count=1.
- ESTABILIZA:
  - botoes==candidate -> count++.
  - botoes!=candidate and nonzero -> new candidate; count=1.
  - botoes==0 -> ESPERA.
  - When count reaches DEBOUNCE:
    - Candidate is one-hot -> REGISTRA; load jogada=candidate; pulse jogada_valida on that same edge.
    - Candidate is not one-hot -> pulse erro_multiplo; jogada unchanged; -> ESPERA_SOLTAR.
- REGISTRA: unconditional -> ESPERA_SOLTAR.
- ESPERA_SOLTAR: when botoes==0 -> ESPERA if habilita=1, else INATIVO.

Timing:
- If value v is first sampled in ESPERA at edge E0 and held, jogada and jogada_valida update at edge E0+DEBOUNCE.

Timeout counter:
- Cleared on every entry to ESPERA.
- Increments each cycle in ESPERA or ESTABILIZA.
- On reaching TIMEOUT: pulse timeout, go to INATIVO, jogada unchanged.
- Counter width is ceil(log2(TIMEOUT+1)) and it must not wrap.

Simultaneous events:
- Acceptance and timeout on the same edge: acceptance wins and timeout is suppressed.
- erro_multiplo and timeout on the same edge: erro_multiplo wins.

Enable and reset mid-operation:
- habilita=0 in any state -> INATIVO on the next edge; no pulse on that edge; jogada retained.
- Reset mid-debounce or mid-wait discards the candidate and all counts.

Test Plan:
(All with N=4, DEBOUNCE=3, TIMEOUT=20.)
1. Reset, habilita=1, botoes=0100 held from edge 5 -> jogada=0100 and jogada_valida=1 at edge 8 only; db_estado=4 until botoes=0, then 1.
2. botoes bounces 0010,0000,0010,0010,0010 -> bounce returns FSM to ESPERA; single jogada_valida 3 edges after the final 0010 run starts; jogada=0010.
3. botoes=0011 held 3 cycles -> erro_multiplo pulse once; jogada keeps prior value; no jogada_valida; FSM waits for release.
4. habilita=1, botoes=0 for 20 cycles after entering ESPERA -> timeout pulse at edge entry+20; db_estado=0; a later press is ignored while habilita stays in INATIVO path (FSM needs botoes=0 first).
5. botoes=1000 already held when habilita rises -> no capture until release; after release and a new 1000 held for 3 cycles -> jogada_valida.
6. Press 0001, count=2, then reset=1 for one edge -> all outputs 0, state 0; no jogada_valida afterwards without a full new 3-cycle press.
